// File: rtl/weight_shift_driver.sv
// Write-side sequencer for the per-row weight shift register: loads ARRAYHEIGHT words, then drains them.
// Optional macro DRAIN_STALL_EN adds a drain_stall input that pauses the drain phase.
module weight_shift_driver #(
  parameter int DATASIZE    = 8,
  parameter int ARRAYHEIGHT = 4,
  parameter int CNTW        = $clog2(ARRAYHEIGHT + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                s_valid,
  output logic                s_ready,
  input  logic [DATASIZE-1:0] s_data,
`ifdef DRAIN_STALL_EN
  input  logic                drain_stall,
`endif
  output logic                load_en,
  output logic                out_en,
  output logic [DATASIZE-1:0] w_data,
  output logic                busy,
  output logic                done
);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    DRAIN,
    FIN
  } state_t;

  localparam logic [CNTW-1:0] CNT_LAST = CNTW'(ARRAYHEIGHT - 1);

  state_t          state;
  state_t          next_state;
  logic [CNTW-1:0] cnt;
  logic [CNTW-1:0] next_cnt;
  logic            stall;
  logic            handshake;
  logic            drain_step;

`ifdef DRAIN_STALL_EN
  assign stall = drain_stall;
`else
  assign stall = 1'b0;
`endif

  // s_ready is a pure state decode, so a handshake is simply LOAD plus s_valid.
  assign handshake  = (state == LOAD) && s_valid;
  assign drain_step = (state == DRAIN) && !stall;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= next_state;
      cnt   <= next_cnt;
    end
  end

  always_comb begin
    next_state = state;
    next_cnt   = cnt;
    case (state)
      IDLE: begin
        if (start) begin
          next_state = LOAD;
          next_cnt   = '0;
        end
      end
      LOAD: begin
        if (handshake) begin
          if (cnt == CNT_LAST) begin
            next_state = DRAIN;
            next_cnt   = '0;
          end else begin
            next_cnt = cnt + 1'b1;
          end
        end
      end
      DRAIN: begin
        if (drain_step) begin
          if (cnt == CNT_LAST) begin
            next_state = FIN;
            next_cnt   = '0;
          end else begin
            next_cnt = cnt + 1'b1;
          end
        end
      end
      FIN: begin
        next_state = IDLE;
        next_cnt   = '0;
      end
      default: begin
        next_state = IDLE;
        next_cnt   = '0;
      end
    endcase
  end

  always_comb begin
    s_ready = 1'b0;
    load_en = 1'b0;
    out_en  = 1'b0;
    w_data  = '0;
    busy    = 1'b0;
    done    = 1'b0;
    case (state)
      LOAD: begin
        s_ready = 1'b1;
        busy    = 1'b1;
        load_en = handshake;
        if (handshake) w_data = s_data;
      end
      DRAIN: begin
        busy   = 1'b1;
        out_en = drain_step;
      end
      FIN: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_weight_shift_driver.sv
// Table-driven bench for weight_shift_driver (ARRAYHEIGHT=4) with a LIFO shift register model,
// plus a hand sequence for an ARRAYHEIGHT=1 instance and, when DRAIN_STALL_EN is defined, a stall case.
module tb_weight_shift_driver;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       start;
  logic       s_valid;
  logic [7:0] s_data;
  logic       s_ready;
  logic       load_en;
  logic       out_en;
  logic [7:0] w_data;
  logic       busy;
  logic       done;

  logic       start1;
  logic       s_valid1;
  logic [7:0] s_data1;
  logic       s_ready1;
  logic       load_en1;
  logic       out_en1;
  logic [7:0] w_data1;
  logic       busy1;
  logic       done1;

`ifdef DRAIN_STALL_EN
  logic drain_stall;
`endif

  weight_shift_driver #(.DATASIZE(8), .ARRAYHEIGHT(4)) u_dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_data     (s_data),
`ifdef DRAIN_STALL_EN
    .drain_stall(drain_stall),
`endif
    .load_en    (load_en),
    .out_en     (out_en),
    .w_data     (w_data),
    .busy       (busy),
    .done       (done)
  );

  weight_shift_driver #(.DATASIZE(8), .ARRAYHEIGHT(1)) u_dut1 (
    .clk        (clk),
    .rst        (rst),
    .start      (start1),
    .s_valid    (s_valid1),
    .s_ready    (s_ready1),
    .s_data     (s_data1),
`ifdef DRAIN_STALL_EN
    .drain_stall(1'b0),
`endif
    .load_en    (load_en1),
    .out_en     (out_en1),
    .w_data     (w_data1),
    .busy       (busy1),
    .done       (done1)
  );

  typedef struct {
    int         tag;
    bit         rst;
    bit         start;
    bit         valid;
    logic [7:0] data;
    bit         stall;
    logic [12:0] exp;
  } vec_t;

  vec_t       vecs[$];
  logic [7:0] exp_pop[$];
  string      names[5] = '{"basic", "bubbles", "ign_start", "mid_reset", "drain_stall"};

  int checks = 0;
  int passes = 0;
  int done_count = 0;
  int done_count1 = 0;

  // LIFO model of the 4-deep shift register: the last word in is the first word out.
  logic [7:0] stack[4];
  int         sp = 0;
  logic [7:0] popped[$];
  logic [7:0] reg1 = 8'h00;

  always @(posedge clk) begin
    if (!rst) begin
      sp = 0;
      reg1 = 8'h00;
    end else begin
      if (load_en) begin
        if (sp < 4) begin
          stack[sp] = w_data;
          sp++;
        end
      end else if (out_en) begin
        if (sp > 0) begin
          sp--;
          popped.push_back(stack[sp]);
        end else begin
          popped.push_back(8'hEE);
        end
      end
      if (load_en1) reg1 = w_data1;
      if (done) done_count++;
      if (done1) done_count1++;
    end
  end

  task automatic add(input int tag, input bit r, input bit st, input bit v, input logic [7:0] d,
                     input bit sl, input bit rdy, input bit ld, input bit oe, input bit bsy,
                     input bit dn, input logic [7:0] w);
    vec_t x;
    x.tag   = tag;
    x.rst   = r;
    x.start = st;
    x.valid = v;
    x.data  = d;
    x.stall = sl;
    x.exp   = {rdy, ld, oe, bsy, dn, w};
    vecs.push_back(x);
  endtask

  task automatic v_idle(input int tag, input bit st);
    add(tag, 1, st, 0, 8'h00, 0, 0, 0, 0, 0, 0, 8'h00);
  endtask

  task automatic v_load(input int tag, input bit st, input bit v, input logic [7:0] d);
    add(tag, 1, st, v, d, 0, 1, v, 0, 1, 0, v ? d : 8'h00);
  endtask

  task automatic v_drain(input int tag, input bit st, input bit sl);
    add(tag, 1, st, 0, 8'h00, sl, 0, 0, !sl, 1, 0, 8'h00);
  endtask

  task automatic v_fin(input int tag, input bit st);
    add(tag, 1, st, 0, 8'h00, 0, 0, 0, 0, 1, 1, 8'h00);
  endtask

  task automatic check_output(input string name, input int step, input logic [31:0] got,
                              input logic [31:0] expv);
    checks++;
    if (got !== expv)
      $display("[TB] FAIL %s step %0d: got %h, expected %h", name, step, got, expv);
    else
      passes++;
  endtask

  task automatic apply_stimulus(input vec_t x);
    @(negedge clk);
    rst     = x.rst;
    start   = x.start;
    s_valid = x.valid;
    s_data  = x.data;
`ifdef DRAIN_STALL_EN
    drain_stall = x.stall;
`endif
    #1;
  endtask

  function automatic logic [31:0] outs0();
    return {19'd0, s_ready, load_en, out_en, busy, done, w_data};
  endfunction

  function automatic logic [31:0] outs1();
    return {19'd0, s_ready1, load_en1, out_en1, busy1, done1, w_data1};
  endfunction

  initial begin
    logic [7:0] bub_data[7];
    bit         bub_valid[7];
    int         exp_done;

    rst = 1'b0; start = 1'b0; s_valid = 1'b0; s_data = 8'h00;
    start1 = 1'b0; s_valid1 = 1'b0; s_data1 = 8'h00;
`ifdef DRAIN_STALL_EN
    drain_stall = 1'b0;
`endif

    // Basic tile with continuous s_valid.
    v_idle(0, 1);
    v_load(0, 0, 1, 8'h11); v_load(0, 0, 1, 8'h22); v_load(0, 0, 1, 8'h33); v_load(0, 0, 1, 8'h44);
    repeat (4) v_drain(0, 0, 0);
    v_fin(0, 0);
    v_idle(0, 0);
    exp_pop.push_back(8'h44); exp_pop.push_back(8'h33); exp_pop.push_back(8'h22); exp_pop.push_back(8'h11);

    // Bubbles: the data bus carries junk while s_valid is low and must not reach w_data.
    bub_valid = '{1, 0, 0, 1, 1, 0, 1};
    bub_data  = '{8'hA1, 8'h5A, 8'h5A, 8'hA2, 8'hA3, 8'h5A, 8'hA4};
    v_idle(1, 1);
    for (int i = 0; i < 7; i++) v_load(1, 0, bub_valid[i], bub_data[i]);
    repeat (4) v_drain(1, 0, 0);
    v_fin(1, 0);
    v_idle(1, 0);
    exp_pop.push_back(8'hA4); exp_pop.push_back(8'hA3); exp_pop.push_back(8'hA2); exp_pop.push_back(8'hA1);

    // start during LOAD, DRAIN and FIN is ignored; start right after done begins a new tile.
    v_idle(2, 1);
    v_load(2, 0, 1, 8'hB1); v_load(2, 1, 1, 8'hB2); v_load(2, 0, 1, 8'hB3); v_load(2, 0, 1, 8'hB4);
    v_drain(2, 0, 0); v_drain(2, 1, 0); v_drain(2, 0, 0); v_drain(2, 0, 0);
    v_fin(2, 1);
    v_idle(2, 1);
    v_load(2, 0, 1, 8'hC1); v_load(2, 0, 1, 8'hC2); v_load(2, 0, 1, 8'hC3); v_load(2, 0, 1, 8'hC4);
    repeat (4) v_drain(2, 0, 0);
    v_fin(2, 0);
    v_idle(2, 0);
    exp_pop.push_back(8'hB4); exp_pop.push_back(8'hB3); exp_pop.push_back(8'hB2); exp_pop.push_back(8'hB1);
    exp_pop.push_back(8'hC4); exp_pop.push_back(8'hC3); exp_pop.push_back(8'hC2); exp_pop.push_back(8'hC1);

    // Reset after two loads abandons the tile; a fresh tile needs four new handshakes.
    v_idle(3, 1);
    v_load(3, 0, 1, 8'hE1); v_load(3, 0, 1, 8'hE2);
    add(3, 0, 0, 0, 8'h00, 0, 1, 0, 0, 1, 0, 8'h00);
    add(3, 1, 0, 1, 8'hE3, 0, 0, 0, 0, 0, 0, 8'h00);
    repeat (5) v_idle(3, 0);
    v_idle(3, 1);
    v_load(3, 0, 1, 8'hF1); v_load(3, 0, 1, 8'hF2); v_load(3, 0, 1, 8'hF3);
    v_load(3, 0, 0, 8'h77);
    v_load(3, 0, 1, 8'hF4);
    repeat (4) v_drain(3, 0, 0);
    v_fin(3, 0);
    v_idle(3, 0);
    exp_pop.push_back(8'hF4); exp_pop.push_back(8'hF3); exp_pop.push_back(8'hF2); exp_pop.push_back(8'hF1);
    exp_done = 5;

`ifdef DRAIN_STALL_EN
    // Stall for three cycles after the second out_en; done slips by three cycles.
    v_idle(4, 1);
    v_load(4, 0, 1, 8'h61); v_load(4, 0, 1, 8'h62); v_load(4, 0, 1, 8'h63); v_load(4, 0, 1, 8'h64);
    v_drain(4, 0, 0); v_drain(4, 0, 0);
    v_drain(4, 0, 1); v_drain(4, 0, 1); v_drain(4, 0, 1);
    v_drain(4, 0, 0); v_drain(4, 0, 0);
    v_fin(4, 0);
    v_idle(4, 0);
    exp_pop.push_back(8'h64); exp_pop.push_back(8'h63); exp_pop.push_back(8'h62); exp_pop.push_back(8'h61);
    exp_done = 6;
`endif

    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    check_output("reset_state", 0, outs0(), 32'h0);
    check_output("reset_state_ah1", 0, outs1(), 32'h0);

    for (int i = 0; i < vecs.size(); i++) begin
      apply_stimulus(vecs[i]);
      check_output(names[vecs[i].tag], i, outs0(), {19'd0, vecs[i].exp});
    end

    check_output("pop_count", 0, popped.size(), exp_pop.size());
    for (int i = 0; i < exp_pop.size(); i++) begin
      if (i < popped.size())
        check_output("pop_order", i, {24'd0, popped[i]}, {24'd0, exp_pop[i]});
    end
    check_output("done_pulses", 0, done_count, exp_done);

    // ARRAYHEIGHT=1 corner: load in cycle 1, out_en in cycle 2, done in cycle 3.
    @(negedge clk); start1 = 1'b1; #1;
    check_output("ah1_idle", 0, outs1(), 32'h0);
    @(negedge clk); start1 = 1'b0; s_valid1 = 1'b1; s_data1 = 8'hA5; #1;
    check_output("ah1_load", 1, outs1(), {19'd0, 5'b11010, 8'hA5});
    @(negedge clk); s_valid1 = 1'b0; s_data1 = 8'h00; #1;
    check_output("ah1_drain", 2, outs1(), {19'd0, 5'b00110, 8'h00});
    check_output("ah1_reg_out", 2, {24'd0, reg1}, 32'h0000_00A5);
    @(negedge clk); #1;
    check_output("ah1_done", 3, outs1(), {19'd0, 5'b00011, 8'h00});
    @(negedge clk); #1;
    check_output("ah1_back_idle", 4, outs1(), 32'h0);
    check_output("ah1_done_pulses", 0, done_count1, 1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
